// File: rtl/gop_bus_pkg.sv
// Shared definitions for the GOP bus fabric.
//   state_t : fabric FSM encoding (IDLE / WAIT)
//   WAITW   : width of a per-slave wait-state field and the stall counter
//   CNTW    : width of the decode-miss counter
//   FW      : width of the address decode field
package gop_bus_pkg;
   localparam int WAITW = 4;
   localparam int CNTW  = 8;
   localparam int FW    = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Saturating increment for the miss counter.
   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (v == '1) ? v : v + CNTW'(1);
   endfunction
endpackage

// File: rtl/gop_addr_decode.sv
// Combinational slave address decoder.
//   field : 16-bit decode field taken from the CPU address
//   codes : NSLV packed 16-bit match codes (slave i in slice i)
//   masks : NSLV packed 16-bit compare masks (slave i in slice i)
//   hit   : one-hot hitting slave (lowest index wins), zero on a miss
//   idx   : index of the hitting slave, zero on a miss
//   miss  : no slave matched
module gop_addr_decode
   import gop_bus_pkg::*;
#(
   parameter int NSLV = 4,
   parameter int IW   = 2
) (
   input  logic [FW-1:0]      field,
   input  logic [NSLV*FW-1:0] codes,
   input  logic [NSLV*FW-1:0] masks,
   output logic [NSLV-1:0]    hit,
   output logic [IW-1:0]      idx,
   output logic               miss
);
   // Scan from the top down so the lowest matching index is the last to write.
   always_comb begin
      hit  = '0;
      idx  = '0;
      miss = 1'b1;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((field & masks[i*FW +: FW]) == (codes[i*FW +: FW] & masks[i*FW +: FW])) begin
            hit    = '0;
            hit[i] = 1'b1;
            idx    = IW'(i);
            miss   = 1'b0;
         end
      end
   end
endmodule

// File: rtl/gop_bus_fabric.sv
// CPU-to-slave bus fabric with per-slave wait states.
//   clk, res          : clock, asynchronous active-low reset
//   cpu_ab/we/do      : CPU address, write enable, write data
//   cpu_di, cpu_rdy   : read data back to the CPU, ready (low stalls the CPU)
//   slv_sel           : one-hot slave select
//   slv_re / slv_we   : single-cycle commit strobes
//   slv_addr/wdata    : address / write data passed through to the slaves
//   slv_rdata         : packed registered slave read data
//   bus_err, miss_cnt : sticky decode-miss flag and saturating miss count
module gop_bus_fabric
   import gop_bus_pkg::*;
#(
   parameter int                    DW       = 16,
   parameter int                    AW       = 32,
   parameter int                    NSLV     = 4,
   parameter int                    DEC_LO   = 16,
   parameter logic [NSLV*FW-1:0]    SLV_CODE = '0,
   parameter logic [NSLV*FW-1:0]    SLV_MASK = '0,
   parameter logic [NSLV*WAITW-1:0] SLV_WAIT = '0
) (
   input  logic               clk,
   input  logic               res,
   input  logic [AW-1:0]      cpu_ab,
   input  logic               cpu_we,
   input  logic [DW-1:0]      cpu_do,
   output logic [DW-1:0]      cpu_di,
   output logic               cpu_rdy,
   output logic [NSLV-1:0]    slv_sel,
   output logic               slv_re,
   output logic               slv_we,
   output logic [AW-1:0]      slv_addr,
   output logic [DW-1:0]      slv_wdata,
   input  logic [NSLV*DW-1:0] slv_rdata,
   output logic               bus_err,
   output logic [CNTW-1:0]    miss_cnt
);
   localparam int IW   = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int NTAB = 1 << IW;

   state_t             state, state_d;
   logic [WAITW-1:0]   cnt;
   logic [IW-1:0]      s_q, rsel_q;
   logic               rd_q, miss_q;

   logic [NSLV-1:0]    dec_hit, sq_oh;
   logic [IW-1:0]      dec_idx, sel_idx;
   logic               dec_miss, in_wait, hit, miss;

   // Per-slave tables padded to a power of two so any index is in range.
   logic [WAITW-1:0]   wait_tab  [NTAB];
   logic [DW-1:0]      rdata_tab [NTAB];

   for (genvar g = 0; g < NTAB; g++) begin : g_tab
      if (g < NSLV) begin : g_real
         assign wait_tab[g]  = SLV_WAIT[g*WAITW +: WAITW];
         assign rdata_tab[g] = slv_rdata[g*DW +: DW];
         assign sq_oh[g]     = (s_q == IW'(g));
      end else begin : g_pad
         assign wait_tab[g]  = '0;
         assign rdata_tab[g] = '0;
      end
   end

   gop_addr_decode #(.NSLV(NSLV), .IW(IW)) u_dec (
      .field (cpu_ab[DEC_LO+FW-1:DEC_LO]),
      .codes (SLV_CODE),
      .masks (SLV_MASK),
      .hit   (dec_hit),
      .idx   (dec_idx),
      .miss  (dec_miss)
   );

   // While waiting the latched slave owns the bus; the live address is ignored.
   assign in_wait   = (state == ST_WAIT);
   assign hit       = in_wait | ~dec_miss;
   assign miss      = ~in_wait & dec_miss;
   assign sel_idx   = in_wait ? s_q : dec_idx;
   assign slv_sel   = in_wait ? sq_oh : dec_hit;
   assign slv_addr  = cpu_ab;
   assign slv_wdata = cpu_do;
   assign slv_we    = cpu_we & cpu_rdy & hit;
   assign slv_re    = ~cpu_we & cpu_rdy & hit;
   assign cpu_di    = rd_q ? rdata_tab[rsel_q] : {DW{miss_q}};

   always_comb begin
      state_d = state;
      cpu_rdy = 1'b1;
      case (state)
         ST_IDLE: if (!dec_miss && wait_tab[dec_idx] != '0) begin
            cpu_rdy = 1'b0;
            state_d = ST_WAIT;
         end
         ST_WAIT: if (cnt != '0) cpu_rdy = 1'b0;
                  else           state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         s_q      <= '0;
         rsel_q   <= '0;
         rd_q     <= 1'b0;
         miss_q   <= 1'b0;
         bus_err  <= 1'b0;
         miss_cnt <= '0;
      end else begin
         state <= state_d;
         // cnt holds the stalls still to come after the current one.
         if (!in_wait && state_d == ST_WAIT) begin
            cnt <= wait_tab[dec_idx] - WAITW'(1);
            s_q <= dec_idx;
         end else if (in_wait && cnt != '0) begin
            cnt <= cnt - WAITW'(1);
         end
         if (cpu_rdy) begin
            rsel_q <= sel_idx;
            rd_q   <= ~cpu_we & hit;
            miss_q <= miss & ~cpu_we;
         end
         if (miss) begin
            bus_err  <= 1'b1;
            miss_cnt <= sat_inc(miss_cnt);
         end
      end
   end
endmodule

// File: tb/tb_gop_bus_fabric.sv
// Directed bench for gop_bus_fabric: RAM/ROM/UART/LED map, UART has 2 wait states.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_gop_bus_fabric;
   import gop_bus_pkg::*;

   localparam int DW = 16, AW = 32, NSLV = 4;
   localparam logic [AW-1:0] IDLE_AB = 32'hfffd_0000; // LED write of zero between tests

   logic              clk = 1'b0, res = 1'b0;
   logic [AW-1:0]     cpu_ab = '0;
   logic              cpu_we = 1'b0;
   logic [DW-1:0]     cpu_do = '0;
   logic [DW-1:0]     cpu_di;
   logic              cpu_rdy, slv_re, slv_we, bus_err;
   logic [NSLV-1:0]   slv_sel;
   logic [AW-1:0]     slv_addr;
   logic [DW-1:0]     slv_wdata;
   logic [NSLV*DW-1:0] slv_rdata = {16'h00c3, 16'h5a5a, 16'hbeef, 16'h1234};
   logic [CNTW-1:0]   miss_cnt;

   int n_cmp = 0, n_err = 0;

   gop_bus_fabric #(
      .DW(DW), .AW(AW), .NSLV(NSLV), .DEC_LO(16),
      .SLV_CODE({16'h00fd, 16'h00fe, 16'h00ff, 16'h0000}),
      .SLV_MASK({16'h00ff, 16'h00ff, 16'h00ff, 16'h8000}),
      .SLV_WAIT({4'd0, 4'd2, 4'd0, 4'd0})
   ) dut (
      .clk(clk), .res(res), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
      .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .slv_sel(slv_sel), .slv_re(slv_re),
      .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
      .slv_rdata(slv_rdata), .bus_err(bus_err), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check the bus handshake outputs in one go: {rdy, sel, re, we}.
   task automatic chk_bus(input string tag, input logic rdy, input logic [3:0] sel,
                          input logic re, input logic we);
      chk(tag, {25'd0, cpu_rdy, slv_sel, slv_re, slv_we}, {25'd0, rdy, sel, re, we});
   endtask

   task automatic drive(input logic [AW-1:0] ab, input logic we, input logic [DW-1:0] d);
      @(negedge clk);
      cpu_ab = ab; cpu_we = we; cpu_do = d;
      #1;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_di", cpu_di, 16'h0000);
      chk("rst_err", bus_err, 1'b0);
      chk("rst_cnt", miss_cnt, 8'd0);
      chk_bus("rst_bus", 1'b1, 4'b0001, 1'b1, 1'b0);
      @(negedge clk); res = 1'b1;

      // Zero-wait RAM read
      drive(32'h0000_0010, 1'b0, 16'h0);
      chk_bus("ram_rd", 1'b1, 4'b0001, 1'b1, 1'b0);
      drive(IDLE_AB, 1'b1, 16'h0);
      chk("ram_di", cpu_di, 16'h1234);
      drive(IDLE_AB, 1'b1, 16'h0);
      chk("ram_di_clr", cpu_di, 16'h0000);

      // UART write, 2 stalls; address wanders during WAIT and must be ignored
      drive(32'hfffe_0000, 1'b1, 16'h0041);
      chk_bus("uart_s1", 1'b0, 4'b0100, 1'b0, 1'b0);
      drive(32'h0000_0010, 1'b1, 16'h0041);
      chk_bus("uart_s2", 1'b0, 4'b0100, 1'b0, 1'b0);
      drive(32'h0000_0010, 1'b1, 16'h0041);
      chk_bus("uart_c", 1'b1, 4'b0100, 1'b0, 1'b1);
      chk("uart_wd", slv_wdata, 16'h0041);
      drive(IDLE_AB, 1'b1, 16'h0);
      chk_bus("uart_done", 1'b1, 4'b1000, 1'b0, 1'b1);

      // Decode miss
      drive(32'hfffc_0000, 1'b0, 16'h0);
      chk_bus("miss_bus", 1'b1, 4'b0000, 1'b0, 1'b0);
      drive(IDLE_AB, 1'b1, 16'h0);
      chk("miss_di", cpu_di, 16'hffff);
      chk("miss_err", bus_err, 1'b1);
      chk("miss_cnt1", miss_cnt, 8'd1);

      // Back-to-back reads LED, ROM, RAM
      drive(32'hfffd_0000, 1'b0, 16'h0);
      chk_bus("b2b_led", 1'b1, 4'b1000, 1'b1, 1'b0);
      drive(32'hffff_0003, 1'b0, 16'h0);
      chk_bus("b2b_rom", 1'b1, 4'b0010, 1'b1, 1'b0);
      chk("b2b_di_led", cpu_di, 16'h00c3);
      drive(32'h0000_0004, 1'b0, 16'h0);
      chk_bus("b2b_ram", 1'b1, 4'b0001, 1'b1, 1'b0);
      chk("b2b_di_rom", cpu_di, 16'hbeef);
      drive(IDLE_AB, 1'b1, 16'h0);
      chk("b2b_di_ram", cpu_di, 16'h1234);

      // UART read aborted by reset in the second stall cycle
      drive(32'hfffe_0001, 1'b0, 16'h0);
      chk_bus("abort_s1", 1'b0, 4'b0100, 1'b0, 1'b0);
      drive(32'hfffe_0001, 1'b0, 16'h0);
      chk_bus("abort_s2", 1'b0, 4'b0100, 1'b0, 1'b0);
      res = 1'b0;
      #1;
      chk_bus("abort_rst", 1'b0, 4'b0100, 1'b0, 1'b0);
      chk("abort_err", bus_err, 1'b0);
      chk("abort_cnt", miss_cnt, 8'd0);
      chk("abort_di", cpu_di, 16'h0000);
      @(negedge clk);
      #1;
      chk_bus("abort_hold", 1'b0, 4'b0100, 1'b0, 1'b0);
      @(negedge clk); res = 1'b1;
      #1;
      chk_bus("rst_s1", 1'b0, 4'b0100, 1'b0, 1'b0);
      drive(32'hfffe_0001, 1'b0, 16'h0);
      chk_bus("rst_s2", 1'b0, 4'b0100, 1'b0, 1'b0);
      drive(32'hfffe_0001, 1'b0, 16'h0);
      chk_bus("rst_c", 1'b1, 4'b0100, 1'b1, 1'b0);
      drive(IDLE_AB, 1'b1, 16'h0);
      chk("rst_uart_di", cpu_di, 16'h5a5a);

      // Miss counter saturation
      for (int i = 0; i < 300; i++) begin
         drive(32'hfffc_0000, 1'b0, 16'h0);
         if (i == 9) chk("sat_cnt9", miss_cnt, 8'd9);
      end
      drive(IDLE_AB, 1'b1, 16'h0);
      chk("sat_cnt", miss_cnt, 8'd255);
      chk("sat_err", bus_err, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
